hash_drbg_sha256: RTL and testbench
===================================

Name: hash_drbg_sha256

Overview:
- Simplified Hash_DRBG deterministic random bit generator built on an internal iterative single-block SHA-256 core.
- Seeds from a 256-bit entropy word and serves 256-bit random words over a level handshake.
- Re-seeds itself from a hash chain after a fixed number of outputs.
- Sits in the scrambler key path; master and slave instances fed the same entropy produce identical streams.

Parameters:
- BITS_GENERATOR_MAX_CYCLE, default 16: number of generate operations per seed before an automatic reseed.
- SEED_GENERATOR_MAX_CYCLE, default 16: number of chained seeds before the seed chain wraps.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-high reset. The port keeps the codebase name; asserted = 1.
- is_master_mode  in  1  selects the seed source when the seed chain wraps.
- next_seed  in  1  single-cycle pulse; forces an immediate reseed.
- next_bits  in  1  level request for one random word.
- catch_up_mode  in  1  when 1, generates run without waiting for next_bits.
- entropy  in  256  instantiation seed; sampled when instantiation starts.
- init_ready  out  1  1 while seeded and idle or generating; 0 during any seeding.
- next_bits_ready  out  1  generate-done flag.
- random_bits  out  256  last generated word.
- reseed_counter  out  64  index of the current seed (1 = first seed).

Behaviour:
- SHA-256 core: one 512-bit block per hash.
  - Message = 8-bit tag || 256-bit value || standard SHA-256 padding (length 264).
  - 66 cycles per hash: 1 load cycle, 64 round cycles, 1 final-add cycle.
- Reset: all outputs 0; V = C = 0; seed_idx = 0; gen_cnt = 0; state INST. Reset mid-operation aborts any hash.
- States: INST, RESEED, IDLE, GEN, DONE.
- INST (entered the first cycle after reset release):
  - V = H(0x00||entropy), then C = H(0x01||V).
  - reseed_counter = 1, gen_cnt = 0, init_ready rises, go to IDLE.
- IDLE: if next_bits = 1 or catch_up_mode = 1, go to GEN. next_seed has priority over next_bits in the same cycle.
- GEN:
  - random_bits = H(0x02||V).
  - V = V + C + reseed_counter, mod 2^256.
  - gen_cnt++.
  - If catch_up_mode = 1, skip DONE and return to IDLE (random_bits still updated, next_bits_ready stays 0). Otherwise go to DONE.
- DONE:
  - next_bits_ready = 1, held while next_bits = 1.
  - First cycle with next_bits = 0: next_bits_ready = 0.
  - Then go to RESEED if gen_cnt == BITS_GENERATOR_MAX_CYCLE, else IDLE.
- RESEED (also entered from IDLE on a next_seed pulse):
  - init_ready = 0 on the first cycle.
  - If reseed_counter < SEED_GENERATOR_MAX_CYCLE: V = H(0x03||V), C = H(0x01||V), reseed_counter++.
  - Else (wrap), depends on is_master_mode:
    - is_master_mode = 1: re-run INST with the current entropy; reseed_counter = 1.
    - is_master_mode = 0: continue the chain as above; reseed_counter++ (no wrap).
  - Then gen_cnt = 0, init_ready = 1, go to IDLE.
- next_seed pulses arriving outside IDLE are ignored.
- Two instances with equal entropy, parameters and request order produce identical random_bits sequences, regardless of handshake timing.

Test Plan:
- Reset, entropy = 0, release reset, next_bits held 1 → init_ready rises within 140 cycles; reseed_counter = 1; first random_bits equals model H(0x02||V0).
- Parameters 3/3, slave mode, next_bits dropped on each ready and re-raised 3 cycles later → 9 next_bits_ready rising edges; init_ready rises exactly 3 times; reseed_counter steps 1→2→3; each init_ready falls before re-rising.
- Parameters 3/3, master mode, run 10 outputs → after the 9th output init_ready re-rises with reseed_counter = 1; the 10th word equals the 1st word.
- next_bits held high after ready → next_bits_ready stays 1 and no new generate starts; drop next_bits → ready clears next cycle.
- next_seed pulse in IDLE after 1 output → immediate reseed; reseed_counter = 2; gen_cnt restarts (3 more outputs before the next auto reseed).
- catch_up_mode = 1 with next_bits = 0 → generates advance silently to a reseed; then clear catch_up_mode → next word matches the model's 4th word; reset asserted mid-GEN → outputs 0 next cycle.

Source files
------------

// File: rtl/hash_drbg_sha256.sv
// Hash-based random bit generator: an iterative SHA-256 core hashing tag||value
// blocks, plus a seeding/generate FSM with automatic chained reseeding.

module hash_drbg_sha256_core (
  input  logic         clk,
  input  logic         srst,
  input  logic         start,
  input  logic [7:0]   tag,
  input  logic [255:0] value,
  output logic         done,
  output logic [255:0] digest
);
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [511:0] block;
  logic [255:0] work_reg, final_sum, digest_reg;
  logic [31:0]  w_reg [16];
  logic [31:0]  wa, wb, wc, wd, we, wf, wg, wh, t1, t2, w_new;
  logic [5:0]   round_reg;
  logic         busy_reg, final_reg, done_reg;

  // Fixed-length message: tag(8) + value(256) bits, so the padding is constant.
  assign block = {tag, value, 1'b1, 183'd0, 64'd264};
  assign {wa, wb, wc, wd, we, wf, wg, wh} = work_reg;
  assign t1 = wh + (rotr(we, 6) ^ rotr(we, 11) ^ rotr(we, 25)) + ((we & wf) ^ (~we & wg))
            + K[round_reg] + w_reg[0];
  assign t2 = (rotr(wa, 2) ^ rotr(wa, 13) ^ rotr(wa, 22)) + ((wa & wb) ^ (wa & wc) ^ (wb & wc));
  assign w_new = (rotr(w_reg[14], 17) ^ rotr(w_reg[14], 19) ^ (w_reg[14] >> 10)) + w_reg[9]
               + (rotr(w_reg[1], 7) ^ rotr(w_reg[1], 18) ^ (w_reg[1] >> 3)) + w_reg[0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sum
      assign final_sum[gi*32 +: 32] = IV[gi*32 +: 32] + work_reg[gi*32 +: 32];
    end
  endgenerate

  always_ff @(posedge clk) begin
    done_reg <= 1'b0;
    if (srst) begin
      busy_reg   <= 1'b0;
      final_reg  <= 1'b0;
      round_reg  <= '0;
      work_reg   <= '0;
      digest_reg <= '0;
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
    end else if (start && !busy_reg && !final_reg) begin
      work_reg  <= IV;
      round_reg <= '0;
      busy_reg  <= 1'b1;
      for (int i = 0; i < 16; i++) w_reg[i] <= block[511 - 32*i -: 32];
    end else if (busy_reg) begin
      // Sliding 16-word schedule window: w_reg[0] is always W[round].
      work_reg  <= {t1 + t2, wa, wb, wc, wd + t1, we, wf, wg};
      for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
      w_reg[15] <= w_new;
      round_reg <= round_reg + 6'd1;
      if (round_reg == 6'd63) begin
        busy_reg  <= 1'b0;
        final_reg <= 1'b1;
      end
    end else if (final_reg) begin
      digest_reg <= final_sum;
      done_reg   <= 1'b1;
      final_reg  <= 1'b0;
    end
  end

  assign done   = done_reg;
  assign digest = digest_reg;
endmodule

module hash_drbg_sha256 #(
  parameter int unsigned BITS_GENERATOR_MAX_CYCLE = 16,
  parameter int unsigned SEED_GENERATOR_MAX_CYCLE = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         is_master_mode,
  input  logic         next_seed,
  input  logic         next_bits,
  input  logic         catch_up_mode,
  input  logic [255:0] entropy,
  output logic         init_ready,
  output logic         next_bits_ready,
  output logic [255:0] random_bits,
  output logic [63:0]  reseed_counter
);
  typedef enum logic [2:0] {ST_INST, ST_RESEED, ST_IDLE, ST_GEN, ST_DONE} state_t;

  localparam logic [31:0] GEN_MAX  = 32'(BITS_GENERATOR_MAX_CYCLE);
  localparam logic [63:0] SEED_MAX = 64'(SEED_GENERATOR_MAX_CYCLE);

  state_t       state_reg;
  logic [255:0] v_reg, c_reg, random_bits_reg, hash_value_reg, hash_digest, v_step;
  logic [63:0]  reseed_counter_reg;
  logic [31:0]  gen_cnt_reg;
  logic [7:0]   hash_tag_reg;
  logic         busy_reg, phase_reg, hash_start_reg, hash_done;
  logic         init_ready_reg, next_bits_ready_reg;

  hash_drbg_sha256_core u_core (
    .clk    (clk),
    .srst   (reset_n),
    .start  (hash_start_reg),
    .tag    (hash_tag_reg),
    .value  (hash_value_reg),
    .done   (hash_done),
    .digest (hash_digest)
  );

  assign v_step = v_reg + c_reg + {192'd0, reseed_counter_reg};

  always_ff @(posedge clk) begin
    hash_start_reg <= 1'b0;
    if (reset_n) begin
      state_reg           <= ST_INST;
      v_reg               <= '0;
      c_reg               <= '0;
      random_bits_reg     <= '0;
      reseed_counter_reg  <= '0;
      gen_cnt_reg         <= '0;
      busy_reg            <= 1'b0;
      phase_reg           <= 1'b0;
      hash_tag_reg        <= '0;
      hash_value_reg      <= '0;
      init_ready_reg      <= 1'b0;
      next_bits_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        // Seeding is two chained hashes: V from tag 00/03, then C = H(01||V).
        ST_INST, ST_RESEED: begin
          if (!busy_reg) begin
            if (state_reg == ST_RESEED && reseed_counter_reg >= SEED_MAX && is_master_mode) begin
              state_reg <= ST_INST;
            end else begin
              hash_start_reg <= 1'b1;
              busy_reg       <= 1'b1;
              phase_reg      <= 1'b0;
              hash_tag_reg   <= (state_reg == ST_INST) ? 8'h00 : 8'h03;
              hash_value_reg <= (state_reg == ST_INST) ? entropy : v_reg;
            end
          end else if (hash_done) begin
            if (!phase_reg) begin
              v_reg          <= hash_digest;
              hash_start_reg <= 1'b1;
              hash_tag_reg   <= 8'h01;
              hash_value_reg <= hash_digest;
              phase_reg      <= 1'b1;
            end else begin
              c_reg              <= hash_digest;
              busy_reg           <= 1'b0;
              gen_cnt_reg        <= '0;
              init_ready_reg     <= 1'b1;
              state_reg          <= ST_IDLE;
              reseed_counter_reg <= (state_reg == ST_INST) ? 64'd1 : reseed_counter_reg + 64'd1;
            end
          end
        end
        ST_IDLE: begin
          if (next_seed) begin
            init_ready_reg <= 1'b0;
            state_reg      <= ST_RESEED;
          end else if (next_bits || catch_up_mode) begin
            state_reg <= ST_GEN;
          end
        end
        ST_GEN: begin
          if (!busy_reg) begin
            hash_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
            hash_tag_reg   <= 8'h02;
            hash_value_reg <= v_reg;
          end else if (hash_done) begin
            busy_reg        <= 1'b0;
            random_bits_reg <= hash_digest;
            v_reg           <= v_step;
            gen_cnt_reg     <= gen_cnt_reg + 32'd1;
            // Catch-up skips the handshake but must still honour the reseed interval.
            if (catch_up_mode) begin
              if (gen_cnt_reg + 32'd1 >= GEN_MAX) begin
                init_ready_reg <= 1'b0;
                state_reg      <= ST_RESEED;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              next_bits_ready_reg <= 1'b1;
              state_reg           <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!next_bits) begin
            next_bits_ready_reg <= 1'b0;
            if (gen_cnt_reg >= GEN_MAX) begin
              init_ready_reg <= 1'b0;
              state_reg      <= ST_RESEED;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_INST;
      endcase
    end
  end

  assign init_ready      = init_ready_reg;
  assign next_bits_ready = next_bits_ready_reg;
  assign random_bits     = random_bits_reg;
  assign reseed_counter  = reseed_counter_reg;
endmodule

// File: tb/tb_hash_drbg_sha256.sv
// Directed bench for hash_drbg_sha256 (3 generates per seed, 3 seeds per chain)
// against a behavioural SHA-256 / Hash_DRBG reference model.

module tb_hash_drbg_sha256;
  logic         clk = 1'b0;
  logic         reset_n, is_master_mode, next_seed, next_bits, catch_up_mode;
  logic [255:0] entropy;
  logic         init_ready, next_bits_ready;
  logic [255:0] random_bits;
  logic [63:0]  reseed_counter;

  int tests_run = 0, tests_failed = 0;
  int init_rises = 0, init_falls = 0, ready_rises = 0;

  hash_drbg_sha256 #(.BITS_GENERATOR_MAX_CYCLE(3), .SEED_GENERATOR_MAX_CYCLE(3)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .is_master_mode  (is_master_mode),
    .next_seed       (next_seed),
    .next_bits       (next_bits),
    .catch_up_mode   (catch_up_mode),
    .entropy         (entropy),
    .init_ready      (init_ready),
    .next_bits_ready (next_bits_ready),
    .random_bits     (random_bits),
    .reseed_counter  (reseed_counter)
  );

  always #5 clk = ~clk;
  always @(posedge init_ready) init_rises++;
  always @(negedge init_ready) init_falls++;
  always @(posedge next_bits_ready) ready_rises++;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_block(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [255:0] out;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3]; e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    hv[0] = a; hv[1] = b; hv[2] = c; hv[3] = d; hv[4] = e; hv[5] = f; hv[6] = g; hv[7] = h;
    for (int i = 0; i < 8; i++) out[255 - 32*i -: 32] = hv[i] + H0[i];
    return out;
  endfunction

  function automatic logic [255:0] hsh(input logic [7:0] tag, input logic [255:0] val);
    return sha_block({tag, val, 1'b1, 183'd0, 64'd264});
  endfunction

  logic [255:0] mv, mc;
  logic [63:0]  mcnt;

  task automatic model_inst(input logic [255:0] ent);
    mv = hsh(8'h00, ent);
    mc = hsh(8'h01, mv);
    mcnt = 64'd1;
  endtask

  task automatic model_gen(output logic [255:0] word);
    word = hsh(8'h02, mv);
    mv = mv + mc + {192'd0, mcnt};
  endtask

  task automatic model_reseed(input logic master, input logic [255:0] ent);
    if (mcnt >= 64'd3 && master) begin
      model_inst(ent);
    end else begin
      mv = hsh(8'h03, mv);
      mc = hsh(8'h01, mv);
      mcnt = mcnt + 64'd1;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    while (next_bits_ready !== 1'b1 && n < budget) begin tick(); n++; end
    check({tag, "_ready_timeout"}, {255'd0, next_bits_ready}, 256'd1);
  endtask

  task automatic wait_init(input logic level, input int budget, input string tag);
    int n = 0;
    while (init_ready !== level && n < budget) begin tick(); n++; end
    check({tag, "_init_timeout"}, {255'd0, init_ready}, {255'd0, level});
  endtask

  task automatic apply_reset(input logic [255:0] ent, input logic master);
    reset_n = 1'b1; next_bits = 1'b0; next_seed = 1'b0; catch_up_mode = 1'b0;
    entropy = ent; is_master_mode = master;
    tick(3);
  endtask

  localparam logic [255:0] E1 = 256'h0123456789abcdef_fedcba9876543210_a5a5a5a5c3c3c3c3_0f0f0f0ff0f0f0f0;
  localparam logic [255:0] E2 = 256'hdeadbeefcafef00d_1122334455667788_99aabbccddeeff00_8000000000000001;

  initial begin
    logic [255:0] word, first_word;
    int base_r, base_f, base_ready;

    if (sha_block({24'h616263, 8'h80, 416'd0, 64'd24}) !==
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
      $display("FAIL model_selftest: reference SHA-256 disagrees with the abc vector");
      $fatal(1, "reference model broken");
    end

    // Reset state and first instantiation from zero entropy
    apply_reset(256'd0, 1'b0);
    check("rst_init_ready", {255'd0, init_ready}, 256'd0);
    check("rst_ready", {255'd0, next_bits_ready}, 256'd0);
    check("rst_random", random_bits, 256'd0);
    check("rst_counter", {192'd0, reseed_counter}, 256'd0);
    reset_n = 1'b0; next_bits = 1'b1;
    wait_init(1'b1, 140, "inst");
    check("inst_counter", {192'd0, reseed_counter}, 256'd1);
    model_inst(256'd0);
    wait_ready(200, "first");
    model_gen(word);
    check("first_word", random_bits, word);
    $display("[TB] word seed %0d %h", reseed_counter, random_bits);

    // next_bits held: ready stays up, no new generate
    tick(12);
    check("hold_ready", {255'd0, next_bits_ready}, 256'd1);
    check("hold_word", random_bits, word);
    next_bits = 1'b0;
    tick();
    check("drop_ready", {255'd0, next_bits_ready}, 256'd0);

    // Forced reseed from IDLE restarts the generate count
    tick();
    next_seed = 1'b1;
    tick();
    next_seed = 1'b0;
    check("seed_init_low", {255'd0, init_ready}, 256'd0);
    model_reseed(1'b0, 256'd0);
    wait_init(1'b1, 200, "seed");
    check("seed_counter", {192'd0, reseed_counter}, 256'd2);
    for (int k = 0; k < 3; k++) begin
      next_bits = 1'b1;
      wait_ready(200, "seed_gen");
      model_gen(word);
      check("seed_word", random_bits, word);
      $display("[TB] word seed %0d %h", reseed_counter, random_bits);
      next_bits = 1'b0;
      tick();
    end
    check("seed_auto_reseed", {255'd0, init_ready}, 256'd0);
    model_reseed(1'b0, 256'd0);
    wait_init(1'b1, 200, "seed2");
    check("seed2_counter", {192'd0, reseed_counter}, 256'd3);

    // Slave mode: 9 words over 3 seeds, chain continues past the wrap point
    apply_reset(E1, 1'b0);
    base_r = init_rises; base_f = init_falls; base_ready = ready_rises;
    reset_n = 1'b0; next_bits = 1'b1;
    model_inst(E1);
    for (int k = 0; k < 9; k++) begin
      wait_ready(400, "slave");
      model_gen(word);
      check("slave_word", random_bits, word);
      check("slave_counter", {192'd0, reseed_counter}, {192'd0, mcnt});
      $display("[TB] word seed %0d %h", reseed_counter, random_bits);
      if (k == 8) begin
        check("slave_ready_edges", 256'(ready_rises - base_ready), 256'd9);
        check("slave_init_rises", 256'(init_rises - base_r), 256'd3);
        check("slave_init_falls", 256'(init_falls - base_f), 256'd2);
      end
      next_bits = 1'b0;
      tick(3);
      if (k % 3 == 2) model_reseed(1'b0, E1);
      next_bits = 1'b1;
    end
    wait_init(1'b1, 200, "slave_wrap");
    check("slave_wrap_counter", {192'd0, reseed_counter}, 256'd4);

    // Master mode: chain wraps back to instantiation, stream repeats
    apply_reset(E1, 1'b1);
    reset_n = 1'b0; next_bits = 1'b1;
    model_inst(E1);
    first_word = '0;
    for (int k = 0; k < 10; k++) begin
      wait_ready(400, "master");
      model_gen(word);
      if (k == 0) first_word = word;
      check("master_word", random_bits, word);
      check("master_counter", {192'd0, reseed_counter}, {192'd0, mcnt});
      $display("[TB] word seed %0d %h", reseed_counter, random_bits);
      if (k == 9) check("master_repeat", random_bits, first_word);
      next_bits = 1'b0;
      tick();
      if (k % 3 == 2) model_reseed(1'b1, E1);
      next_bits = 1'b1;
    end

    // Catch-up: silent generates up to the reseed, then the 4th word on request
    apply_reset(E2, 1'b0);
    reset_n = 1'b0;
    wait_init(1'b1, 200, "cu");
    model_inst(E2);
    base_ready = ready_rises;
    catch_up_mode = 1'b1;
    wait_init(1'b0, 400, "cu_run");
    catch_up_mode = 1'b0;
    for (int k = 0; k < 3; k++) model_gen(word);
    check("cu_last_word", random_bits, word);
    check("cu_silent", 256'(ready_rises - base_ready), 256'd0);
    model_reseed(1'b0, E2);
    wait_init(1'b1, 200, "cu_reseed");
    check("cu_counter", {192'd0, reseed_counter}, 256'd2);
    next_bits = 1'b1;
    wait_ready(200, "cu_fourth");
    model_gen(word);
    check("cu_fourth_word", random_bits, word);
    $display("[TB] word seed %0d %h", reseed_counter, random_bits);

    // Reset in the middle of a generate
    next_bits = 1'b0;
    tick();
    next_bits = 1'b1;
    tick(20);
    reset_n = 1'b1;
    tick();
    check("midgen_init_ready", {255'd0, init_ready}, 256'd0);
    check("midgen_ready", {255'd0, next_bits_ready}, 256'd0);
    check("midgen_random", random_bits, 256'd0);
    check("midgen_counter", {192'd0, reseed_counter}, 256'd0);
    reset_n = 1'b0;
    model_inst(E2);
    wait_ready(400, "after_reset");
    model_gen(word);
    check("after_reset_word", random_bits, word);
    $display("[TB] word seed %0d %h", reseed_counter, random_bits);
    next_bits = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
